// File: rtl/audio_output_compressor.sv
// Output-stage dynamic range compressor: envelope follower, sequential gain divider,
// gain and volume multiply with saturation, fixed 20-cycle latency per sample.
module audio_output_compressor #(
   parameter int THRESH     = 8192,
   parameter int ATTACK_SH  = 2,
   parameter int RELEASE_SH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] audio_in,
   input  logic               audio_valid,
   input  logic        [8:0]  vol,
   output logic signed [15:0] audio_out,
   output logic               audio_ready,
   output logic               busy,
   output logic               overrun
);

   typedef enum logic [2:0] {
      S_IDLE, S_ENV, S_DIV, S_MUL_G, S_MUL_V, S_OUT
   } state_t;

   // THRESH*32768 as a 32-bit dividend; its upper half is always below env here.
   localparam logic [31:0] DIVIDEND = 32'(THRESH) << 15;

   state_t state, state_nx;

   logic signed [15:0] sample_r;
   logic        [8:0]  vol_r;
   logic        [15:0] abs_r;
   logic        [15:0] env;
   logic               unity_r;
   logic        [16:0] rem_r;
   logic        [15:0] quo_r;
   logic        [15:0] div_r;
   logic        [3:0]  cnt;
   logic signed [16:0] y1_r;

   logic               accept;
   logic        [15:0] abs_in;
   logic        [15:0] env_new;
   logic        [16:0] trial;
   logic               ge;
   logic        [16:0] gain;
   logic signed [33:0] prod_g;
   logic signed [33:0] rnd_g;
   logic signed [27:0] prod_v;
   logic signed [27:0] rnd_v;
   logic signed [19:0] y2;
   logic signed [15:0] y2_sat;

   assign accept      = audio_valid && ((state == S_IDLE) || (state == S_OUT));
   assign audio_ready = (state == S_OUT);
   assign busy        = (state != S_IDLE) && (state != S_OUT);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = S_ENV;
         S_ENV:   state_nx = S_DIV;
         S_DIV:   if (cnt == 4'd15) state_nx = S_MUL_G;
         S_MUL_G: state_nx = S_MUL_V;
         S_MUL_V: state_nx = S_OUT;
         S_OUT:   state_nx = accept ? S_ENV : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      abs_in = 16'd0;
      if (audio_in == -16'sd32768) abs_in = 16'd32767;
      else if (audio_in[15])       abs_in = 16'(-audio_in);
      else                         abs_in = 16'(audio_in);
   end

   always_comb begin
      env_new = env;
      if (abs_r > env) env_new = env + ((abs_r - env) >> ATTACK_SH);
      else             env_new = env - ((env - abs_r) >> RELEASE_SH);
   end

   // One restoring step: shift the next dividend bit in, subtract when it fits.
   assign trial = {rem_r[15:0], quo_r[15]};
   assign ge    = (trial >= {1'b0, div_r});
   assign gain  = unity_r ? 17'd32768 : {1'b0, quo_r};

   assign prod_g = sample_r * $signed({1'b0, gain});
   assign rnd_g  = prod_g + 34'sd16384;
   assign prod_v = y1_r * $signed({1'b0, vol_r});
   assign rnd_v  = prod_v + 28'sd128;
   assign y2     = rnd_v[27:8];

   always_comb begin
      y2_sat = y2[15:0];
      if (y2 > 20'sd32767)        y2_sat = 16'sh7fff;
      else if (y2 < -20'sd32768)  y2_sat = -16'sd32768;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_r  <= '0;
         vol_r     <= '0;
         abs_r     <= '0;
         env       <= '0;
         unity_r   <= 1'b0;
         rem_r     <= '0;
         quo_r     <= '0;
         div_r     <= '0;
         cnt       <= '0;
         y1_r      <= '0;
         audio_out <= '0;
         overrun   <= 1'b0;
      end else begin
         if (audio_valid && busy) overrun <= 1'b1;
         if (accept) begin
            sample_r <= audio_in;
            vol_r    <= vol;
            abs_r    <= abs_in;
         end
         case (state)
            S_ENV: begin
               env     <= env_new;
               unity_r <= (env_new <= 16'(THRESH));
               rem_r   <= {1'b0, DIVIDEND[31:16]};
               quo_r   <= DIVIDEND[15:0];
               div_r   <= env_new;
               cnt     <= '0;
            end
            S_DIV: begin
               rem_r <= ge ? (trial - {1'b0, div_r}) : trial;
               quo_r <= {quo_r[14:0], ge};
               cnt   <= cnt + 4'd1;
            end
            S_MUL_G: y1_r      <= rnd_g[31:15];
            S_MUL_V: audio_out <= y2_sat;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/audio_output_compressor.md
AUDIO_OUTPUT_COMPRESSOR -- requirements
Module: audio_output_compressor

Interface
REQ-001 Parameters, one per line: name, default, meaning; THRESH, 8192, envelope compression threshold, legal range 1..32767.
REQ-002 ATTACK_SH, 2, right-shift applied to the envelope rise step.
REQ-003 RELEASE_SH, 8, right-shift applied to the envelope fall step.
REQ-004 Ports, one per line: name direction width meaning; clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 audio_in  in  16 signed  denoised sample from the noise-removal processor output.
REQ-007 audio_valid  in  1  one-cycle strobe qualifying audio_in, driven by the processor's audio_ready.
REQ-008 vol  in  9 unsigned  user volume, Q1.8 format (256 = unity), sampled with audio_in.
REQ-009 audio_out  out  16 signed  compressed, volume-scaled sample.
REQ-010 audio_ready  out  1  one-cycle strobe qualifying a new audio_out.
REQ-011 busy  out  1  high while a sample is in flight.
REQ-012 overrun  out  1  sticky flag, set when a sample is dropped.

Function
REQ-013 Acceptance: a sample is accepted when audio_valid=1 and busy=0; audio_in and vol are captured in that cycle, called cycle k.
REQ-014 Fixed latency: audio_ready=1 for exactly one cycle, in cycle k+20; audio_out updates in that same cycle and holds until the next audio_ready.
REQ-015 busy timing: busy=1 in cycles k+1..k+19, and 0 in cycle k+20 and whenever idle.
REQ-016 Back-to-back: a sample presented in cycle k+20 is accepted.
REQ-017 Overrun: audio_valid=1 while busy=1 drops the sample and sets overrun=1, with no effect on the in-flight sample; overrun clears only on rst.
REQ-018 States: IDLE -> ENV (1 cycle) -> DIV (16 cycles) -> MUL_G (1) -> MUL_V (1) -> OUT (1) -> IDLE; acceptance in OUT re-enters ENV.
REQ-019 Magnitude: abs = |audio_in|, with -32768 mapped to 32767.
REQ-020 Envelope, 16-bit unsigned register env, updated in ENV:
- if abs > env: env += (abs - env) >> ATTACK_SH;
- otherwise: env -= (env - abs) >> RELEASE_SH.
REQ-021 Gain, Q1.15 unsigned, 17 bits:
- if env <= THRESH: gain = 32768 (unity);
- otherwise: gain = floor(THRESH*32768/env), computed by a 16-iteration sequential restoring divider in DIV.
REQ-022 DIV always runs 16 cycles, so latency is independent of the gain path.
REQ-023 MUL_G: y1 = (audio_in*gain + 16384) >>> 15, arithmetic shift, full-precision intermediate.
REQ-024 MUL_V: y2 = (y1*vol + 128) >>> 8.
REQ-025 Saturation: y2 saturates to [-32768, 32767] before it is registered to audio_out; there is no wrap-around.
REQ-026 The divider never sees env=0, because the unity path is taken whenever env <= THRESH.

Reset
REQ-027 While rst=1 at a clock edge: state=IDLE, audio_out=0, audio_ready=0, busy=0, overrun=0, env=0, divider registers cleared.
REQ-028 Reset mid-operation aborts the in-flight sample; no audio_ready is produced for it afterwards.
REQ-029 audio_valid asserted in the same cycle as rst=1 is ignored.

Verification
REQ-030 After reset, audio_in=1000, vol=256 -> env=250, unity gain, audio_out=1000, audio_ready exactly 20 cycles later.
REQ-031 After reset, two samples of 32767 with vol=256, the second accepted at cycle k+20:
- first -> env=8191, audio_out=32767;
- second -> env=14335, gain=18725, audio_out=18724.
REQ-032 After reset, audio_in=-32768, vol=511 -> y1=-32768, y2=-65408, saturated audio_out=-32768.
REQ-033 Accept at k; audio_valid again at k+5 -> dropped, overrun=1, single audio_ready at k+20; a valid at k+20 is accepted, with ready at k+40.
REQ-034 Accept at k, then rst pulse at k+10 -> no audio_ready, audio_out=0, busy=0, env=0; the next sample behaves as in REQ-030.
REQ-035 audio_in=12345, vol=0 -> audio_out=0, audio_ready at k+20.
